// File: rtl/uart_tx_core.sv
// Transmit-only 8N1 UART with an 8-bit memory-mapped slave port.
// TXDATA at 0x0 starts a frame when idle; STATUS at 0x1 reports {busy, ready}.
module uart_tx_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] avms_address_i,
  input  logic       avms_read_i,
  input  logic       avms_write_i,
  input  logic [7:0] avms_writedata_i,
  output logic [7:0] avms_readdata_o,
  output logic       uart_txd_o
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [7:0]       readdata_q, readdata_d;

  logic tx_ready;
  logic baud_wrap;
  logic write_accept;

  assign tx_ready     = (state_q == S_IDLE);
  assign baud_wrap    = (baud_cnt_q == CNT_MAX);
  assign write_accept = avms_write_i && (avms_address_i == ADDR_TXDATA) && tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      readdata_q <= readdata_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;

    unique case (state_q)
      S_IDLE: begin
        // Counters sit at zero in idle so the first bit is a full DIV long.
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (write_accept) begin
          state_d = S_START;
          shift_d = avms_writedata_i;
        end
      end
      S_START: begin
        if (baud_wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_wrap) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // txd is registered from the next state, so the line changes on the same
  // edge as the FSM and stays glitch-free.
  always_comb begin
    txd_d      = 1'b1;
    readdata_d = readdata_q;

    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[bit_idx_d];
      default: txd_d = 1'b1;
    endcase

    if (avms_read_i) begin
      if (avms_address_i == ADDR_STATUS) readdata_d = {6'b0, ~tx_ready, tx_ready};
      else                               readdata_d = 8'h00;
    end
  end

  assign uart_txd_o      = txd_q;
  assign avms_readdata_o = readdata_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: register-access vector table plus a line monitor
// that decodes frames and compares them against a queue of expected bytes.
module tb_uart_tx_core;

  // DIV = 100 / 6 = 16 (truncated) keeps frames short.
  localparam int CLK_FREQ  = 100;
  localparam int BAUD_RATE = 6;
  localparam int DIV       = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] avms_address_i;
  logic       avms_read_i;
  logic       avms_write_i;
  logic [7:0] avms_writedata_i;
  logic [7:0] avms_readdata_o;
  logic       uart_txd_o;

  always #5 clk = ~clk;

  uart_tx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .avms_address_i  (avms_address_i),
    .avms_read_i     (avms_read_i),
    .avms_write_i    (avms_write_i),
    .avms_writedata_i(avms_writedata_i),
    .avms_readdata_o (avms_readdata_o),
    .uart_txd_o      (uart_txd_o)
  );

  typedef struct {
    logic [3:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic [7:0] exp_rd;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         frames_seen = 0;
  int         frames_exp  = 0;

  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  int         mon_k = 0;
  logic [9:0] mon_bits = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Line monitor: samples on the falling edge, at the middle of each bit.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd_o === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % DIV == DIV / 2) begin
        mon_k           = mon_cnt / DIV;
        mon_bits[mon_k] = uart_txd_o;
        if (mon_k == 9) begin
          mon_active = 1'b0;
          frames_seen++;
          check("start_bit", 32'(mon_bits[0]), 32'd0);
          check("stop_bit", 32'(mon_bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_frame: got 0x%0h expected no frame", mon_bits[8:1]);
          end else begin
            check("frame_data", 32'(mon_bits[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input bit accept);
    avms_address_i   = a;
    avms_writedata_i = d;
    avms_write_i     = 1'b1;
    tick();
    avms_write_i     = 1'b0;
    avms_writedata_i = 8'($urandom);
    if (accept) begin
      exp_q.push_back(d);
      frames_exp++;
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    avms_address_i = a;
    avms_read_i    = 1'b1;
    tick();
    avms_read_i    = 1'b0;
    d              = avms_readdata_o;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[10];
    logic [7:0] rd;
    logic [7:0] poll_bytes[6];
    int         n;
    int         idx;

    vecs[0] = '{4'h1, 1'b0, 8'h00, 1'b1, 8'h01};
    vecs[1] = '{4'h3, 1'b1, 8'h55, 1'b0, 8'h01};
    vecs[2] = '{4'h3, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{4'h1, 1'b1, 8'hFF, 1'b1, 8'h01};
    vecs[4] = '{4'h0, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{4'hF, 1'b1, 8'hAA, 1'b0, 8'h00};
    vecs[6] = '{4'h1, 1'b0, 8'h00, 1'b1, 8'h01};
    vecs[7] = '{4'h2, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[8] = '{4'h1, 1'b0, 8'h00, 1'b1, 8'h01};
    vecs[9] = '{4'hF, 1'b0, 8'h00, 1'b1, 8'h00};
    poll_bytes = '{8'h17, 8'h99, 8'h87, 8'h37, 8'h57, 8'h47};

    rst_i            = 1'b1;
    avms_address_i   = 4'h0;
    avms_read_i      = 1'b0;
    avms_write_i     = 1'b0;
    avms_writedata_i = 8'h00;

    // Reset
    ticks(3);
    check("reset_txd", 32'(uart_txd_o), 32'd1);
    check("reset_readdata", 32'(avms_readdata_o), 32'h00);
    rst_i = 1'b0;
    bus_read(4'h1, rd);
    check("reset_status", 32'(rd), 32'h01);

    // Register map, unmapped writes and read-data hold
    for (int i = 0; i < 10; i++) begin
      avms_address_i   = vecs[i].addr;
      avms_write_i     = vecs[i].wr;
      avms_writedata_i = vecs[i].wdata;
      avms_read_i      = vecs[i].rd;
      tick();
      avms_write_i = 1'b0;
      avms_read_i  = 1'b0;
      check($sformatf("vec%0d_readdata", i), 32'(avms_readdata_o), 32'(vecs[i].exp_rd));
    end
    ticks(12 * DIV);
    check("no_frame_unmapped", 32'(frames_seen), 32'd0);
    check("idle_txd", 32'(uart_txd_o), 32'd1);

    // Single frame 0x17: start length, busy status, ready edge
    bus_write(4'h0, 8'h17, 1'b1);
    n = 0;
    while (uart_txd_o === 1'b0 && n < 4 * DIV) begin
      n++;
      tick();
    end
    check("start_len", 32'(n), 32'(DIV));
    bus_read(4'h1, rd);
    check("status_busy", 32'(rd), 32'h02);
    ticks(10 * DIV - DIV - 2);
    bus_read(4'h1, rd);
    check("status_last_stop_cycle", 32'(rd), 32'h02);
    bus_read(4'h1, rd);
    check("status_ready_after_frame", 32'(rd), 32'h01);
    wait_drain("drain_single", 20 * DIV);

    // Write in the final stop cycle is dropped; the next cycle is accepted
    bus_write(4'h0, 8'h57, 1'b1);
    ticks(10 * DIV - 1);
    bus_write(4'h0, 8'hE1, 1'b0);
    bus_write(4'h0, 8'h3C, 1'b1);
    wait_drain("drain_stop_edge", 40 * DIV);

    // Polling loop: six back-to-back frames
    ticks(2 * DIV);
    idx = 0;
    n   = 0;
    while (idx < 6 && n < 400) begin
      bus_read(4'h1, rd);
      if (rd[0]) begin
        bus_write(4'h0, poll_bytes[idx], 1'b1);
        idx++;
        ticks(4);
      end else begin
        ticks(5);
      end
      n++;
    end
    check("poll_all_written", 32'(idx), 32'd6);
    wait_drain("drain_poll", 20 * DIV);

    // Write while busy is dropped
    ticks(2 * DIV);
    bus_write(4'h0, 8'h99, 1'b1);
    ticks(100);
    bus_write(4'h0, 8'hAA, 1'b0);
    wait_drain("drain_busy", 20 * DIV);
    n = 0;
    repeat (3 * DIV) begin
      tick();
      if (uart_txd_o !== 1'b1) n++;
    end
    check("idle_after_busy_drop", 32'(n), 32'd0);

    // Reset in the middle of data bit 4 of 0x87
    bus_write(4'h0, 8'h87, 1'b1);
    ticks(5 * DIV + DIV / 2);
    check("bit4_before_reset", 32'(uart_txd_o), 32'd0);
    rst_i = 1'b1;
    void'(exp_q.pop_back());
    frames_exp--;
    tick();
    rst_i = 1'b0;
    check("reset_mid_txd", 32'(uart_txd_o), 32'd1);
    bus_read(4'h1, rd);
    check("reset_mid_status", 32'(rd), 32'h01);
    bus_write(4'h0, 8'h37, 1'b1);
    wait_drain("drain_after_reset", 20 * DIV);

    ticks(12 * DIV);
    check("frame_count", 32'(frames_seen), 32'(frames_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(uart_txd_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
